// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - data-memory map constants, STATUS bit indices and address decode
package mem_map_pkg;

    localparam logic [15:0] MMIO_BASE   = 16'hF800;
    localparam logic [15:0] ADDR_TIMER  = 16'hFFF0;
    localparam logic [15:0] ADDR_LED    = 16'hFFF1;
    localparam logic [15:0] ADDR_STATUS = 16'hFFF2;
    localparam logic [15:0] ADDR_TXFIFO = 16'hFFF3;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_TIMER,
        SEL_LED,
        SEL_STATUS,
        SEL_TXFIFO,
        SEL_NONE
    } sel_e;

    function automatic sel_e decode(input logic [15:0] addr);
        if (addr < MMIO_BASE)          return SEL_RAM;
        else if (addr == ADDR_TIMER)   return SEL_TIMER;
        else if (addr == ADDR_LED)     return SEL_LED;
        else if (addr == ADDR_STATUS)  return SEL_STATUS;
        else if (addr == ADDR_TXFIFO)  return SEL_TXFIFO;
        else                           return SEL_NONE;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, registered flags, head word visible on dout
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign dout = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - CPU data-bus responder: RAM, MMIO page, TX FIFO stream; MEM_RESP_TIMER_EN adds the timer
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_stb_800k,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_out,
    input  logic        mem_write_en,
    output logic [15:0] data_in,
    output logic [15:0] led_out,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int RAM_DEPTH = 2 ** RAM_ADDR_WIDTH;
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;

    sel_e                      w_sel;
    logic                      w_wr;
    logic                      w_pop;
    logic                      w_fifo_wr;
    logic                      w_full;
    logic                      w_empty;
    logic [CW-1:0]             w_count;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
    logic [15:0]               w_timer;
    logic [15:0]               w_rd;

    logic [15:0]               r_ram [0:RAM_DEPTH-1];
    logic [15:0]               r_data_in;
    logic [15:0]               r_led;
    logic                      r_ovf;

    assign w_sel     = decode(data_addr);
    assign w_wr      = clk_stb_800k & mem_write_en;
    assign w_pop     = tx_valid & tx_ready;
    assign w_fifo_wr = w_wr & (w_sel == SEL_TXFIFO);
    assign w_ram_idx = data_addr[RAM_ADDR_WIDTH-1:0];

    assign data_in  = r_data_in;
    assign led_out  = r_led;
    assign tx_valid = ~w_empty;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (w_fifo_wr),
        .pop   (w_pop),
        .din   (data_out),
        .dout  (tx_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (w_wr && (w_sel == SEL_RAM))
            r_ram[w_ram_idx] <= data_out;
    end

`ifdef MEM_RESP_TIMER_EN
    logic [15:0] r_timer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_timer <= '0;
        else if (w_wr && (w_sel == SEL_TIMER))
            r_timer <= data_out;
        else if (clk_stb_800k)
            r_timer <= r_timer + 16'd1;
    end

    assign w_timer = r_timer;
`else
    assign w_timer = '0;
`endif

    always_comb begin
        w_rd = '0;
        case (w_sel)
            SEL_RAM:    w_rd = r_ram[w_ram_idx];
            SEL_TIMER:  w_rd = w_timer;
            SEL_LED:    w_rd = r_led;
            SEL_STATUS: begin
                w_rd[ST_OVF]   = r_ovf;
                w_rd[ST_FULL]  = w_full;
                w_rd[ST_EMPTY] = w_empty;
            end
            SEL_TXFIFO: w_rd = 16'(w_count);
            default:    w_rd = '0;
        endcase
    end

    // Read data samples pre-edge state, so a RAM write on the same edge reads back the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_in <= '0;
            r_led     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_data_in <= w_rd;
            if (w_wr && (w_sel == SEL_LED))
                r_led <= data_out;
            if (w_fifo_wr && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (w_wr && (w_sel == SEL_STATUS) && data_out[ST_OVF])
                r_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - bench for data_mem_responder: queue/array model plus directed vectors
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_stb_800k = 1'b0;
    logic [15:0] data_addr = 16'h0000;
    logic [15:0] data_out = 16'h0000;
    logic        mem_write_en = 1'b0;
    logic [15:0] data_in;
    logic [15:0] led_out;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .clk_stb_800k (clk_stb_800k),
        .data_addr    (data_addr),
        .data_out     (data_out),
        .mem_write_en (mem_write_en),
        .data_in      (data_in),
        .led_out      (led_out),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: RAM as a sparse map, FIFO as a queue.
    logic [15:0] m_ram [int];
    logic [15:0] m_q [$];
    logic [15:0] m_led;
    logic [15:0] m_timer;
    logic        m_ovf;
    logic [15:0] m_din;
    logic        m_known;
    logic [15:0] m_rd;
    logic        m_rd_known;
    logic        m_pop;
    logic        m_wr;
    logic        m_was_full;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_q.delete();
                m_led   = 16'h0000;
                m_timer = 16'h0000;
                m_ovf   = 1'b0;
                m_din   = 16'h0000;
                m_known = 1'b1;
            end else begin
                m_rd       = 16'h0000;
                m_rd_known = 1'b1;
                if (data_addr < 16'hF800) begin
                    if (m_ram.exists(int'(data_addr) % 4096)) m_rd = m_ram[int'(data_addr) % 4096];
                    else m_rd_known = 1'b0;
                end else if (data_addr == 16'hFFF0) m_rd = m_timer;
                else if (data_addr == 16'hFFF1) m_rd = m_led;
                else if (data_addr == 16'hFFF2) m_rd = {13'd0, m_ovf, m_q.size() == 8, m_q.size() == 0};
                else if (data_addr == 16'hFFF3) m_rd = 16'(m_q.size());

                m_wr       = clk_stb_800k && mem_write_en;
                m_pop      = (m_q.size() > 0) && tx_ready;
                m_was_full = (m_q.size() == 8);
                if (m_pop) void'(m_q.pop_front());
                if (m_wr && data_addr == 16'hFFF3) begin
                    if (!m_was_full || m_pop) m_q.push_back(data_out);
                    else m_ovf = 1'b1;
                end
                if (m_wr && data_addr < 16'hF800) m_ram[int'(data_addr) % 4096] = data_out;
                if (m_wr && data_addr == 16'hFFF1) m_led = data_out;
                if (m_wr && data_addr == 16'hFFF2 && data_out[2]) m_ovf = 1'b0;
`ifdef MEM_RESP_TIMER_EN
                if (m_wr && data_addr == 16'hFFF0) m_timer = data_out;
                else if (clk_stb_800k) m_timer = m_timer + 16'd1;
`endif
                m_din   = m_rd;
                m_known = m_rd_known;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (m_known) check("model data_in", data_in, m_din);
                check("model led_out", led_out, m_led);
                check("model tx_valid", {15'd0, tx_valid}, {15'd0, m_q.size() != 0});
                if (m_q.size() != 0) check("model tx_data", tx_data, m_q[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        data_addr    = a;
        data_out     = d;
        clk_stb_800k = 1'b1;
        mem_write_en = 1'b1;
        tick();
        clk_stb_800k = 1'b0;
        mem_write_en = 1'b0;
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp);
        data_addr    = a;
        clk_stb_800k = 1'b0;
        mem_write_en = 1'b0;
        tick();
        check(name, data_in, exp);
    endtask

    initial begin
        #2;
        check("reset data_in", data_in, 16'h0000);
        check("reset led_out", led_out, 16'h0000);
        check("reset tx_valid", {15'd0, tx_valid}, 16'h0000);
        check("reset tx_data", tx_data, 16'h0000);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();

        // RAM write, read back, alias, read-during-write
        wr(16'h0010, 16'hBEEF);
        rd("ram read", 16'h0010, 16'hBEEF);
        rd("ram alias", 16'h1010, 16'hBEEF);
        wr(16'h0010, 16'h1234);
        check("ram rdw old", data_in, 16'hBEEF);
        rd("ram new", 16'h0010, 16'h1234);
        rd("mmio hole", 16'hF900, 16'h0000);

        // Writes without strobe are ignored
        data_addr = 16'hFFF1; data_out = 16'h1234; mem_write_en = 1'b1; clk_stb_800k = 1'b0;
        repeat (10) tick();
        check("led gated", led_out, 16'h0000);
        data_out = 16'h00A5; clk_stb_800k = 1'b1;
        tick();
        clk_stb_800k = 1'b0; mem_write_en = 1'b0;
        check("led strobe", led_out, 16'h00A5);
        rd("led read", 16'hFFF1, 16'h00A5);

        // Overfill, drain, clear overflow
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) wr(16'hFFF3, 16'(i));
        rd("status full ovf", 16'hFFF2, 16'h0006);
        rd("fifo count 8", 16'hFFF3, 16'h0008);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain valid", {15'd0, tx_valid}, 16'h0001);
            check("drain data", tx_data, 16'(i));
            tick();
        end
        check("drained valid", {15'd0, tx_valid}, 16'h0000);
        rd("status empty ovf", 16'hFFF2, 16'h0005);
        wr(16'hFFF2, 16'h0004);
        rd("status cleared", 16'hFFF2, 16'h0001);

        // Push into a full FIFO on the same edge as a pop
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(16'hFFF3, 16'h0010 + 16'(i));
        rd("status full", 16'hFFF2, 16'h0002);
        tx_ready = 1'b1;
        wr(16'hFFF3, 16'h0042);
        tx_ready = 1'b0;
        rd("count after pp", 16'hFFF3, 16'h0008);
        rd("no ovf after pp", 16'hFFF2, 16'h0002);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("pp data", tx_data, (i == 8) ? 16'h0042 : 16'h0010 + 16'(i));
            tick();
        end
        check("pp drained", {15'd0, tx_valid}, 16'h0000);
        tx_ready = 1'b0;

        // Timer load and wrap
        wr(16'hFFF0, 16'hFFFE);
        clk_stb_800k = 1'b1;
        repeat (3) tick();
        clk_stb_800k = 1'b0;
`ifdef MEM_RESP_TIMER_EN
        rd("timer wrap", 16'hFFF0, 16'h0001);
`else
        rd("timer absent", 16'hFFF0, 16'h0000);
`endif

        // Asynchronous reset with words queued
        for (int i = 0; i < 3; i++) wr(16'hFFF3, 16'h0070 + 16'(i));
        wr(16'hFFF1, 16'h5A5A);
        rd("pre-reset ram", 16'h0010, 16'h1234);
        check("pre-reset valid", {15'd0, tx_valid}, 16'h0001);
        #2 rst = 1'b0;
        #1;
        check("async tx_valid", {15'd0, tx_valid}, 16'h0000);
        check("async data_in", data_in, 16'h0000);
        check("async led_out", led_out, 16'h0000);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();
        check("post-reset valid", {15'd0, tx_valid}, 16'h0000);
        rd("post-reset status", 16'hFFF2, 16'h0001);
        rd("post-reset count", 16'hFFF3, 16'h0000);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
